// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
// FIFO read-port bundle between a synchronous FIFO and the drain stage that
// empties it.
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, registered by the FIFO on the edge that samples fifo_rd_en
//   fifo_rd_en  pop request issued by the drain stage
// The master modport is the drain (consumer) side, the slave modport is the FIFO side.

interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a synchronous FIFO one word at a time and sends each word as an
// asynchronous serial frame: start bit, data LSB first, optional parity bit,
// stop bit. Only one word is ever in flight, because a pop is issued only from IDLE.
// Parameters:
//   WIDTH         data bits per frame (must match the FIFO width)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY_EN     1 inserts a parity bit after the data bits
//   PARITY_ODD    0 = even parity, 1 = odd parity
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   fifo     FIFO read port (master side: drives fifo_rd_en)
//   tx       registered serial line, idles high
//   busy     registered, high whenever the state is not IDLE
//   tx_done  registered one-cycle pulse in the first IDLE cycle after a frame

module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_uart_tx_if.master      fifo,
    output logic                tx,
    output logic                busy,
    output logic                tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             parity_bit, parity_next;
    logic             tx_next;
    logic             baud_end;

    assign baud_end = (baud_cnt == BAUD_MAX);

    // The pop is purely combinational so the FIFO registers dout on the same
    // edge that moves us into LOAD; the word is then valid during LOAD.
    assign fifo.fifo_rd_en = (state == IDLE) && !fifo.fifo_empty;

    // Next-state logic. tx is computed from the next state and next shift
    // register so the registered line changes on the same edge as the state.
    always_comb begin
        next_state  = state;
        baud_next   = baud_end ? '0 : baud_cnt + CNT_W'(1);
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        tx_next     = 1'b1;

        case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo.fifo_empty) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                baud_next   = '0;
                shift_next  = fifo.fifo_dout;
                parity_next = (^fifo.fifo_dout) ^ (PARITY_ODD != 0);
                next_state  = START;
            end
            START: begin
                if (baud_end) begin
                    bit_next   = '0;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == BIT_MAX) begin
                        bit_next   = '0;
                        next_state = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Every state entry starts a fresh bit period.
        if (next_state != state) begin
            baud_next = '0;
        end

        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    // State and output registers; reset returns the line to idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= next_state;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
            busy       <= (next_state != IDLE);
            tx_done    <= (state == STOP) && (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Three drain stages (no parity, even parity, odd parity), each fed by a small
// behavioural FIFO, all at WIDTH = 8 and CLKS_PER_BIT = 4.

module tb_fifo_uart_tx;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] push_en = 3'b000;
    logic [7:0] push_data [3];
    logic [2:0] tx_w, busy_w, done_w, rd_w, empty_w;

    int   cyc = 0;
    int   rd_cnt [3];
    int   done_cnt [3];
    int   checks = 0;
    int   fails = 0;
    int   last_low = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rd_w[i] === 1'b1) rd_cnt[i] <= rd_cnt[i] + 1;
            if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gen_ch
        fifo_uart_tx_if #(.WIDTH(8)) ifc ();

        logic [7:0] mem [16];
        logic [3:0] wp, rp;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       do_push, do_pop;

        assign do_push = push_en[g];
        assign do_pop  = ifc.fifo_rd_en && (cnt != 5'd0);

        // FIFO shares rst_n and therefore reports empty while in reset.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp   <= 4'd0;
                rp   <= 4'd0;
                cnt  <= 5'd0;
                dout <= 8'd0;
            end else begin
                if (do_push) begin
                    mem[wp] <= push_data[g];
                    wp      <= wp + 4'd1;
                end
                if (do_pop) begin
                    dout <= mem[rp];
                    rp   <= rp + 4'd1;
                end
                cnt <= cnt + {4'd0, do_push} - {4'd0, do_pop};
            end
        end

        assign ifc.fifo_empty = (cnt == 5'd0);
        assign ifc.fifo_dout  = dout;
        assign rd_w[g]        = ifc.fifo_rd_en;
        assign empty_w[g]     = ifc.fifo_empty;

        fifo_uart_tx #(
            .WIDTH        (8),
            .CLKS_PER_BIT (4),
            .PARITY_EN    ((g > 0) ? 1 : 0),
            .PARITY_ODD   ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .fifo    (ifc),
            .tx      (tx_w[g]),
            .busy    (busy_w[g]),
            .tx_done (done_w[g])
        );
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_word(input int sel, input logic [7:0] d, input logic p, input bit track);
        exp_t e;
        @(negedge clk);
        push_en[sel]   = 1'b1;
        push_data[sel] = d;
        if (track) begin
            e.data = d;
            e.par  = p;
            exp_q.push_back(e);
        end
    endtask

    task automatic end_push(input int sel);
        @(negedge clk);
        push_en[sel] = 1'b0;
    endtask

    task automatic wait_start(input int sel, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_w[sel] === 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    // Receives one frame, popping its expected word from the scoreboard and
    // checking every cycle of every bit slot, then the tx_done pulse.
    task automatic capture_frame(input int sel, input bit pe, output int t_start);
        bit          ok;
        exp_t        e;
        int          nslots;
        logic [10:0] expv;
        bit          bad, early, idle;
        logic        got;

        wait_start(sel, ok, t_start);
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL start_bit dut%0d: got tx=%b for 200 cycles, want 0", sel, tx_w[sel]);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL scoreboard dut%0d: got unexpected frame, want none", sel);
            return;
        end
        e      = exp_q.pop_front();
        nslots = pe ? 11 : 10;
        expv   = '1;
        expv[0] = 1'b0;
        for (int k = 0; k < 8; k++) expv[k+1] = e.data[k];
        if (pe) expv[9] = e.par;

        early = 1'b0;
        idle  = 1'b0;
        for (int s = 0; s < nslots; s++) begin
            bad = 1'b0;
            got = tx_w[sel];
            for (int c = 0; c < 4; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                if (tx_w[sel] !== expv[s]) begin
                    bad = 1'b1;
                    got = tx_w[sel];
                end
                if (tx_w[sel] === 1'b0) last_low = cyc;
                if (done_w[sel] !== 1'b0) early = 1'b1;
                if (busy_w[sel] !== 1'b1) idle = 1'b1;
            end
            checks++;
            if (bad) begin
                fails++;
                $display("[TB] FAIL frame_slot%0d dut%0d word %h: got tx=%b, want %b for 4 cycles",
                         s, sel, e.data, got, expv[s]);
            end
        end
        checks++;
        if (early || idle) begin
            fails++;
            $display("[TB] FAIL in_frame_flags dut%0d: got done_seen=%b not_busy=%b, want 0 0", sel, early, idle);
        end

        @(negedge clk);
        checks++;
        if (done_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || tx_w[sel] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL frame_end dut%0d: got tx_done=%b busy=%b tx=%b, want 1 0 1",
                     sel, done_w[sel], busy_w[sel], tx_w[sel]);
        end
        @(negedge clk);
        checks++;
        if (done_w[sel] !== 1'b0 || tx_w[sel] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL done_pulse_width dut%0d: got tx_done=%b tx=%b, want 0 1", sel, done_w[sel], tx_w[sel]);
        end
    endtask

    task automatic test_reset;
        bit ok;
        int t;
        int rd0;
        bit saw_rd, saw_low, saw_busy;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || rd_w[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_state dut%0d: got tx=%b busy=%b done=%b rd_en=%b, want 1 0 0 0",
                         i, tx_w[i], busy_w[i], done_w[i], rd_w[i]);
            end
        end
        rst_n = 1'b1;

        saw_rd = 1'b0; saw_low = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_w !== 3'b000) saw_rd = 1'b1;
            if (tx_w !== 3'b111) saw_low = 1'b1;
            if (busy_w !== 3'b000) saw_busy = 1'b1;
        end
        checks++;
        if (saw_rd || saw_low || saw_busy) begin
            fails++;
            $display("[TB] FAIL empty_hold: got rd_seen=%b tx_low_seen=%b busy_seen=%b, want 0 0 0",
                     saw_rd, saw_low, saw_busy);
        end

        fork
            begin
                push_word(0, 8'h00, 1'b0, 1'b0);
                end_push(0);
            end
            wait_start(0, ok, t);
        join
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL reset_pre_start: got no start bit, want start bit");
        end
        repeat (6) @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_data: got tx=%b busy=%b, want 0 1", tx_w[0], busy_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_frame: got tx=%b busy=%b done=%b rd_en=%b, want 1 0 0 0",
                     tx_w[0], busy_w[0], done_w[0], rd_w[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_cnt[0];
        saw_rd = 1'b0; saw_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_w[0] !== 1'b0) saw_rd = 1'b1;
            if (tx_w[0] !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_rd || saw_low || (rd_cnt[0] - rd0) != 0 || empty_w[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL post_reset_idle: got rd_seen=%b tx_low_seen=%b pops=%0d empty=%b, want 0 0 0 1",
                     saw_rd, saw_low, rd_cnt[0] - rd0, empty_w[0]);
        end
    endtask

    task automatic test_single_byte;
        int t1, rd0, dn0;
        rd0 = rd_cnt[0];
        dn0 = done_cnt[0];
        fork
            begin
                push_word(0, 8'hA5, 1'b0, 1'b1);
                end_push(0);
            end
            capture_frame(0, 1'b0, t1);
        join
        repeat (10) @(negedge clk);
        checks++;
        if ((rd_cnt[0] - rd0) != 1 || (done_cnt[0] - dn0) != 1) begin
            fails++;
            $display("[TB] FAIL single_counts: got pops=%0d done_pulses=%0d, want 1 1",
                     rd_cnt[0] - rd0, done_cnt[0] - dn0);
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, ll, rd0;
        rd0 = rd_cnt[0];
        fork
            begin
                push_word(0, 8'h00, 1'b0, 1'b1);
                push_word(0, 8'hFF, 1'b0, 1'b1);
                end_push(0);
            end
            begin
                capture_frame(0, 1'b0, t1);
                ll = last_low;
                capture_frame(0, 1'b0, t2);
            end
        join
        repeat (10) @(negedge clk);
        checks++;
        if ((t2 - t1) != 42) begin
            fails++;
            $display("[TB] FAIL b2b_start_period: got %0d cycles, want 42", t2 - t1);
        end
        checks++;
        if ((t2 - ll - 1) != 6) begin
            fails++;
            $display("[TB] FAIL b2b_line_high: got %0d cycles, want 6", t2 - ll - 1);
        end
        checks++;
        if ((rd_cnt[0] - rd0) != 2) begin
            fails++;
            $display("[TB] FAIL b2b_pops: got %0d, want 2", rd_cnt[0] - rd0);
        end
    endtask

    task automatic test_parity(input int sel, input logic [7:0] d1, input logic p1,
                               input logic [7:0] d2, input logic p2);
        int t1, t2;
        fork
            begin
                push_word(sel, d1, p1, 1'b1);
                push_word(sel, d2, p2, 1'b1);
                end_push(sel);
            end
            begin
                capture_frame(sel, 1'b1, t1);
                capture_frame(sel, 1'b1, t2);
            end
        join
        repeat (10) @(negedge clk);
        checks++;
        if ((t2 - t1) != 46) begin
            fails++;
            $display("[TB] FAIL parity_start_period dut%0d: got %0d cycles, want 46", sel, t2 - t1);
        end
    endtask

    task automatic test_fifo_burst;
        int t, rd0;
        rd0 = rd_cnt[0];
        fork
            begin
                push_word(0, 8'h3C, 1'b0, 1'b1);
                push_word(0, 8'h81, 1'b0, 1'b1);
                push_word(0, 8'h5A, 1'b0, 1'b1);
                push_word(0, 8'hE7, 1'b0, 1'b1);
                end_push(0);
            end
            for (int i = 0; i < 4; i++) capture_frame(0, 1'b0, t);
        join
        repeat (10) @(negedge clk);
        checks++;
        if ((rd_cnt[0] - rd0) != 4 || empty_w[0] !== 1'b1 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL burst_drain: got pops=%0d empty=%b pending=%0d, want 4 1 0",
                     rd_cnt[0] - rd0, empty_w[0], exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) push_data[i] = 8'h00;
        $display("[TB] starting fifo_uart_tx bench");
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity(1, 8'h07, 1'b1, 8'h03, 1'b0);
        test_parity(2, 8'h07, 1'b0, 8'h00, 1'b1);
        test_fifo_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the basic synchronous FIFO. It pops one word at a time through the FIFO's read port (`rd_en` / `dout` / `empty`) and transmits each word as an asynchronous serial frame on `tx`: start bit, data LSB first, optional parity, stop bit. It sits between the FIFO and the pad/line driver, so the FIFO absorbs bursts while this block paces output at the bit rate.

## Interface
- `WIDTH`, 8: data bits per frame; must equal the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN` = 0.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_dout`  input  WIDTH  FIFO `dout`; registered by the FIFO on the edge that samples `rd_en`.
- `fifo_rd_en`  output  1  pop request to the FIFO `rd_en`.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high whenever the state is not IDLE.
- `tx_done`  output  1  one-cycle pulse at the end of each frame.

## Operation
- **States:** IDLE, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `fifo_rd_en` = (state == IDLE) && !`fifo_empty`. This is combinational and never high while `fifo_empty` = 1.
  - If `fifo_rd_en` = 1, go to LOAD. Otherwise stay in IDLE.
- **LOAD** (exactly 1 cycle)
  - `fifo_dout` is now valid. Latch it into the shift register.
  - Compute parity as XOR of the data bits, inverted if `PARITY_ODD`.
  - Go to START. `tx` is driven 0 on the same edge.
- **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx` = shift register bit 0. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right.
  - A bit counter runs 0..WIDTH-1. After bit WIDTH-1, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** `tx` = parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE. `tx_done` is registered high for the first IDLE cycle only.
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`. Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit/state. It is cleared on every state entry.
- **Output registers:** `tx` is registered (glitch-free). `busy` and `tx_done` are registered.
- **Pop rule:** the block pops only in IDLE, so at most one word is in flight. The block never pops while a frame is in progress.
- **Reset mid-frame:**
  - All state clears immediately and `tx` returns to 1.
  - The word in the shift register is lost.
  - `fifo_rd_en` is low while in reset, because the FIFO shares `rst_n` and reports empty.

## Timing
- **Reset values:** state = IDLE, `tx` = 1, `busy` = 0, `tx_done` = 0, counters = 0, shift register = 0.
- **Pop to line:** `fifo_rd_en` high in cycle N. LOAD occurs in cycle N+1. The start bit is on `tx` from cycle N+2.
- **Frame length:** (2 + WIDTH + PARITY_EN) × `CLKS_PER_BIT` cycles, from the first start-bit cycle to the last stop-bit cycle.
- **Back-to-back (FIFO non-empty):**
  - STOP is followed by 1 IDLE cycle (pop) and 1 LOAD cycle.
  - The line is therefore high for `CLKS_PER_BIT` + 2 cycles between frames.
  - Start-bit period = frame length + 2.
- **`tx_done`:** coincides with the IDLE cycle in which the next `fifo_rd_en` may assert.
- **`busy`:** rises in the LOAD cycle and falls in the IDLE cycle where `tx_done` is high.
- **FIFO empty at end of STOP:** the block stays in IDLE with `tx` = 1 and resumes the cycle `fifo_empty` falls.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-DATA with `CLKS_PER_BIT` = 4 → `tx` = 1, `busy` = 0, `tx_done` = 0 immediately. After release, no `fifo_rd_en` until `fifo_empty` = 0.
- **Single byte:** `WIDTH` = 8, `CLKS_PER_BIT` = 4, `PARITY_EN` = 0, push 0xA5.
  - `fifo_rd_en` high for exactly 1 cycle.
  - `tx` = 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles.
  - `tx_done` pulses once, 40 cycles after the start bit begins.
- **Back-to-back:** push 0x00 then 0xFF.
  - Two frames are sent.
  - The line is high for exactly 6 cycles between the first stop bit's start and the second start bit.
  - The second start bit begins 42 cycles after the first.
  - `fifo_rd_en` pulses twice.
- **Even parity:** `PARITY_EN` = 1, `PARITY_ODD` = 0. 0x07 → parity bit 1; 0x03 → parity bit 0. Frame length 44 cycles at `CLKS_PER_BIT` = 4.
- **Odd parity:** `PARITY_ODD` = 1 → 0x07 gives parity bit 0; 0x00 gives parity bit 1.
- **Empty hold:** `fifo_empty` = 1 for 100 cycles → `fifo_rd_en` never high, `tx` constant 1, `busy` = 0. Combined with the FIFO, fill 4 words → all 4 are transmitted in order and the FIFO ends empty.
